// File: rtl/mfp_uart_loader_ahb_sequencer.sv
// mfp_uart_loader_ahb_sequencer: buffers parser byte writes in a FIFO and issues each one as a single AHB-Lite byte write
module mfp_uart_loader_ahb_sequencer #(
  parameter int FIFO_AW = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      write_address,
  input  logic [7:0]       write_byte,
  input  logic             write_enable,
  input  logic             bus_enable,
  input  logic             clear,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic [31:0]      HADDR,
  output logic [2:0]       HBURST,
  output logic             HMASTLOCK,
  output logic [3:0]       HPROT,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  output logic             busy,
  output logic             overflow,
  output logic             error,
  output logic [CNT_W-1:0] write_count
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic [39:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [31:0] addr_q;
  logic [7:0] byte_q;
  logic empty, full, push, pop, done, unused;
  // the kseg strip happens on entry, so the stored address is already physical
  assign unused = ^write_address[31:29];
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}};
    push = write_enable && !full;
    pop = state == IDLE && !empty && bus_enable;
    done = state == DATA && HREADY;
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {3'b000, write_address[28:0], write_byte};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr_q <= '0;
      byte_q <= '0;
      overflow <= 1'b0;
      error <= 1'b0;
      write_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {addr_q, byte_q} <= mem[rd_ptr[FIFO_AW-1:0]];
      end
      state <= pop ? ADDR : state == ADDR ? (HREADY ? DATA : ADDR) : state == DATA && !HREADY ? DATA : IDLE;
      overflow <= clear ? 1'b0 : overflow | (write_enable & full);
      error <= clear ? 1'b0 : error | (done & HRESP);
      write_count <= clear ? '0 : write_count + CNT_W'(done & !HRESP);
    end
  end
  assign HADDR = addr_q;
  assign HBURST = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT = 4'b0000;
  assign HSIZE = 3'b000;
  assign HTRANS = state == ADDR ? 2'b10 : 2'b00;
  assign HWRITE = state == ADDR;
  assign HWDATA = {24'b0, byte_q} << {addr_q[1:0], 3'b000};
  assign busy = state != IDLE || !empty;
endmodule

// File: tb/tb_mfp_uart_loader_ahb_sequencer.sv
// tb_mfp_uart_loader_ahb_sequencer: queue-based reference model plus directed scenarios for the AHB byte-write sequencer
module tb_mfp_uart_loader_ahb_sequencer;
  logic clock = 0, reset = 1;
  logic [31:0] write_address = 0;
  logic [7:0] write_byte = 0;
  logic write_enable = 0, bus_enable = 1, clear = 0, HREADY = 1, HRESP = 0;
  logic [31:0] HADDR, HWDATA;
  logic [2:0] HBURST, HSIZE;
  logic HMASTLOCK, HWRITE, busy, overflow, error;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [15:0] write_count;
  always #5 clock = ~clock;
  mfp_uart_loader_ahb_sequencer dut (
    .clock(clock), .reset(reset), .write_address(write_address), .write_byte(write_byte),
    .write_enable(write_enable), .bus_enable(bus_enable), .clear(clear), .HREADY(HREADY),
    .HRESP(HRESP), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .busy(busy),
    .overflow(overflow), .error(error), .write_count(write_count)
  );
  int total = 0, bad = 0;
  typedef struct packed { logic [31:0] a; logic [7:0] d; } ent_t;
  ent_t q[$];
  ent_t cur = '0;
  int phase = 0;
  logic [15:0] m_cnt = 0;
  logic m_ovf = 0, m_err = 0;
  bit chk_on = 0;
  int ns_cnt = 0;
  logic [1:0] prev_tr = 0;
  logic [31:0] seen_addr[$], seen_wd[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask
  // phase: 0 no transfer, 1 address phase, 2 data phase
  always @(posedge clock) begin : model
    bit was_full;
    was_full = q.size() == 8;
    if (reset) begin
      q.delete();
      phase = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_err = 0;
    end else begin
      if (phase == 2 && HREADY) begin
        if (HRESP) m_err = 1;
        else m_cnt++;
        phase = 0;
      end else if (phase == 1 && HREADY) phase = 2;
      else if (phase == 0 && q.size() != 0 && bus_enable) begin
        cur = q.pop_front();
        phase = 1;
      end
      if (write_enable) begin
        if (was_full) m_ovf = 1;
        else q.push_back(ent_t'({write_address, write_byte}));
      end
      if (clear) begin
        m_cnt = 0;
        m_ovf = 0;
        m_err = 0;
      end
    end
  end
  always @(negedge clock) if (chk_on) begin
    chk("htrans", 32'(HTRANS), phase == 1 ? 32'd2 : 32'd0);
    chk("hwrite", 32'(HWRITE), 32'(phase == 1));
    chk("hconst", 32'({HBURST, HMASTLOCK, HPROT, HSIZE}), 32'd0);
    if (phase == 1) chk("haddr", HADDR, {3'b000, cur.a[28:0]});
    if (phase == 2) chk("hwdata", HWDATA, {24'b0, cur.d} << (8 * cur.a[1:0]));
    chk("busy", 32'(busy), 32'(phase != 0 || q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("error", 32'(error), 32'(m_err));
    chk("write_count", 32'(write_count), 32'(m_cnt));
    if (HTRANS == 2'b10 && prev_tr != 2'b10) begin
      ns_cnt++;
      seen_addr.push_back(HADDR);
    end
    if (prev_tr == 2'b10 && HTRANS != 2'b10) seen_wd.push_back(HWDATA);
    prev_tr = HTRANS;
  end
  task automatic strobe(input logic [31:0] a, input logic [7:0] d);
    write_address = a;
    write_byte = d;
    write_enable = 1;
    @(negedge clock);
    write_enable = 0;
  endtask
  task automatic pulse_clear();
    clear = 1;
    @(negedge clock);
    clear = 0;
  endtask
  task automatic wait_idle(input string n);
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
    chk(n, 32'(busy), 32'd0);
  endtask
  task automatic wait_ns(input int target);
    for (int i = 0; i < 100 && ns_cnt < target; i++) begin
      @(negedge clock);
      #1;
    end
    chk("nonseq_wait", ns_cnt, target);
  endtask
  initial begin
    int base, abase, wbase;
    logic [31:0] hold;
    repeat (2) @(negedge clock);
    chk_on = 1;
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_status", {busy, overflow, error, write_count}, 0);
    reset = 0;
    // single write, zero wait states
    strobe(32'h9FC0_0001, 8'hA5);
    wait_ns(1);
    chk("single_haddr", HADDR, 32'h1FC0_0001);
    chk("single_addrphase", {HTRANS, HWRITE, HSIZE}, {2'b10, 1'b1, 3'b000});
    @(negedge clock);
    chk("single_hwdata", HWDATA, 32'h0000_A500);
    @(negedge clock);
    chk("single_count", 32'(write_count), 1);
    chk("single_busy", 32'(busy), 0);
    // bus_enable low holds off the transfer
    bus_enable = 0;
    strobe(32'h40, 8'h77);
    repeat (4) @(negedge clock);
    chk("gate_no_start", ns_cnt, 1);
    chk("gate_busy", 32'(busy), 1);
    bus_enable = 1;
    wait_ns(2);
    wait_idle("gate_idle");
    chk("gate_count", 32'(write_count), 2);
    // wait states: 3 in address phase, 2 in data phase
    HREADY = 0;
    strobe(32'h102, 8'h3C);
    wait_ns(3);
    hold = HADDR;
    chk("ws_haddr", hold, 32'h102);
    repeat (3) begin
      @(negedge clock);
      chk("ws_addr_hold", {30'(HADDR), HTRANS}, {30'(hold), 2'b10});
    end
    HREADY = 1;
    @(negedge clock);
    HREADY = 0;
    chk("ws_hwdata", HWDATA, 32'h003C_0000);
    repeat (2) begin
      @(negedge clock);
      chk("ws_data_hold", HWDATA, 32'h003C_0000);
      chk("ws_no_count", 32'(write_count), 2);
    end
    HREADY = 1;
    @(negedge clock);
    chk("ws_count", 32'(write_count), 3);
    // burst of 8 back-to-back strobes
    pulse_clear();
    base = ns_cnt;
    abase = seen_addr.size();
    wbase = seen_wd.size();
    for (int i = 0; i < 8; i++) strobe(32'(i), 8'(8'h10 + i));
    wait_idle("burst_idle");
    chk("burst_ovf", 32'(overflow), 0);
    chk("burst_count", 32'(write_count), 8);
    chk("burst_xfers", ns_cnt - base, 8);
    for (int i = 0; i < 8 && abase + i < seen_addr.size() && wbase + i < seen_wd.size(); i++) begin
      chk("burst_addr", seen_addr[abase + i], 32'(i));
      chk("burst_lane", seen_wd[wbase + i], 32'(8'h10 + i) << (8 * (i % 4)));
    end
    // overflow with the slave stalled
    pulse_clear();
    base = ns_cnt;
    HREADY = 0;
    for (int i = 0; i < 10; i++) strobe(32'h200 + 32'(i), 8'(i));
    chk("ovf_set", 32'(overflow), 1);
    HREADY = 1;
    wait_idle("ovf_idle");
    chk("ovf_count", 32'(write_count), 9);
    chk("ovf_xfers", ns_cnt - base, 9);
    pulse_clear();
    chk("ovf_clear", 32'(overflow), 0);
    // two-cycle ERROR response on the 2nd of 3 writes
    base = ns_cnt;
    abase = seen_addr.size();
    for (int i = 0; i < 3; i++) strobe(32'h300 + 32'(i), 8'(8'h50 + i));
    wait_ns(base + 2);
    @(negedge clock);
    HREADY = 0;
    HRESP = 1;
    @(negedge clock);
    HREADY = 1;
    @(negedge clock);
    HRESP = 0;
    chk("err_set", 32'(error), 1);
    wait_idle("err_idle");
    chk("err_count", 32'(write_count), 2);
    chk("err_xfers", ns_cnt - base, 3);
    if (seen_addr.size() >= abase + 3) chk("err_third", seen_addr[abase + 2], 32'h302);
    else chk("err_third_seen", seen_addr.size(), abase + 3);
    pulse_clear();
    chk("err_clear", {error, write_count}, 0);
    // reset while in the address phase with 4 entries queued
    HREADY = 0;
    base = ns_cnt;
    for (int i = 0; i < 5; i++) strobe(32'h400 + 32'(i), 8'(i));
    chk("rstmid_addr", 32'(HTRANS), 2);
    reset = 1;
    @(negedge clock);
    chk("rstmid_htrans", 32'(HTRANS), 0);
    chk("rstmid_busy", 32'(busy), 0);
    reset = 0;
    HREADY = 1;
    repeat (10) @(negedge clock);
    chk("rstmid_quiet", ns_cnt - base, 1);
    chk("rstmid_count", 32'(write_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mfp_uart_loader_ahb_sequencer.md
Name: mfp_uart_loader_ahb_sequencer

Overview:
Sequences byte writes from the UART S-record parser onto the AHB-Lite bus with a proper HREADY/HRESP handshake. It buffers incoming (address, byte) pairs in a small FIFO, so bytes are not lost while a slave inserts wait states. Each buffered byte is issued as a single, non-pipelined, HSIZE byte write. The block sits between the S-record parser and the loader's AHB-Lite master port. It also reports busy, overflow, error and completed-write status to the loader control logic.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (default depth 8 entries)
CNT_W, 16, width of the completed-write counter

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
write_address  in  32  target address of the byte from the parser
write_byte  in  8  data byte from the parser
write_enable  in  1  single-cycle strobe; address and byte are valid this cycle
bus_enable  in  1  when 1, new bus transfers may start
clear  in  1  synchronous clear of overflow, error and write_count
HREADY  in  1  AHB-Lite ready from the slave/mux
HRESP  in  1  AHB-Lite response; 1 = ERROR
HADDR  out  32  AHB address
HBURST  out  3  constant SINGLE (3'b000)
HMASTLOCK  out  1  constant 0
HPROT  out  4  constant 4'b0
HSIZE  out  3  constant byte (3'b000)
HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10)
HWRITE  out  1  1 during the address phase only
HWDATA  out  32  write data, lane-positioned
busy  out  1  FIFO not empty or FSM not IDLE
overflow  out  1  sticky; a write_enable was dropped
error  out  1  sticky; a transfer completed with HRESP=1
write_count  out  CNT_W  number of transfers completed with OKAY; wraps

Behaviour:
- Reset values:
  - FIFO empty; FSM in IDLE.
  - HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0.
  - busy=0, overflow=0, error=0, write_count=0.
  - Reset mid-transfer abandons the transfer and flushes the FIFO. No further bus activity occurs until new writes arrive.
- FIFO:
  - Each entry is {write_address, write_byte}, 40 bits.
  - A push occurs when write_enable=1 and the FIFO is not full. Full is evaluated before any pop in the same cycle.
  - write_enable while full: the entry is dropped and overflow is set to 1.
  - Push and pop in the same non-full cycle: both take effect and the occupancy is unchanged.
  - Read and write pointers are FIFO_AW+1 bits and wrap naturally.
- Address mapping: HADDR = {3'b000, addr[28:0]}. This is a kseg-to-physical strip.
- FSM states and transitions:
  - IDLE: HTRANS=IDLE, HWRITE=0. If the FIFO is not empty and bus_enable=1, pop the head into addr_q/byte_q and go to ADDR.
  - ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR from addr_q. Hold all address-phase signals while HREADY=0. On HREADY=1, go to DATA.
  - DATA: HTRANS=IDLE, HWRITE=0. HWDATA = {24'b0, byte_q} << (8*addr_q[1:0]); all other lanes are 0. Hold HWDATA while HREADY=0. On HREADY=1, complete the transfer:
    - if HRESP=1, set error;
    - otherwise, increment write_count;
    - go to IDLE.
- Minimum cost is 3 cycles per byte (IDLE, ADDR, DATA) with zero wait states.
- On a two-cycle ERROR response, HRESP is sampled only in the cycle where HREADY=1.
- A transfer is never cancelled after ERROR; the FIFO continues draining.
- bus_enable=0 blocks only the IDLE to ADDR transition. An in-flight transfer always completes.
- busy is combinational: (state != IDLE) or FIFO not empty.
- clear zeroes overflow, error and write_count. If clear coincides with a set or increment event, clear wins.
- write_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Single write: write_address=0x9FC0_0001, byte=0xA5, HREADY=1 constant. Required: ADDR one cycle after the strobe with HADDR=0x1FC0_0001, HTRANS=NONSEQ, HWRITE=1, HSIZE=0. Next cycle HWDATA=0x0000_A500. write_count=1 and busy=0 after 3 cycles.
- Wait states: HREADY=0 for 3 cycles in ADDR and 2 cycles in DATA. Required: HADDR/HTRANS/HWDATA stable throughout the stalls; exactly one transfer counted.
- Burst of 8 strobes on consecutive cycles to addresses 0x0..0x7 with HREADY=1. Required:
  - no overflow;
  - 8 transfers in address order, lanes 0,1,2,3,0,1,2,3;
  - write_count=8.
- Overflow: hold HREADY=0 and send 10 strobes. Required: overflow=1 and exactly 9 bytes retained (1 in flight + 8 in FIFO). After releasing HREADY, write_count=9.
- Error: slave returns HRESP=1 with HREADY 0 then 1 on the 2nd of 3 writes. Required: error=1, write_count=2, 3rd write still issued. clear then gives error=0, write_count=0.
- Reset while in ADDR with 4 entries queued. Required: next cycle HTRANS=IDLE, busy=0; no transfers afterwards.
